// File: rtl/adc_dsp_rx.sv
// -----------------------------------------------------------------------------
// adc_dsp_rx
//   Codec ADC receiver for DSP mode A framing. Deserialises ADCDAT (MSB first,
//   left slot then right slot, two's complement) into one signed sample pair
//   per frame. The pair is held on leftSampleOut/rightSampleOut for the echo
//   stage, which samples them on the ADCLRCK rising edge.
//
//   Optional feature macro: ADC_RX_MONO_EN
//     When defined, an extra SUM state registers left+right, and COMMIT loads
//     the average (sum >>> 1) into both outputs. Commit then lands one edge
//     later.
//
// Ports
//   BCLK           in   bit clock, all state updates on the rising edge
//   ADCLRCK        in   frame-sync pulse, also the asynchronous active-high reset
//   ADCDAT         in   serial sample data
//   leftSampleOut  out  last committed left sample (mono: average)
//   rightSampleOut out  last committed right sample (mono: average)
//   sample_valid   out  one-BCLK pulse on the edge the outputs are loaded
//   busy           out  high while a slot is being captured (and during reset)
//   state_o        out  current FSM state, for observation only
//
// Handshake: sample_valid is a push-only strobe with no ready/backpressure.
// It is high for exactly the one BCLK cycle following the edge that loaded
// new values into leftSampleOut/rightSampleOut; the consumer must take the
// pair then or later (the pair holds until the next commit).
// -----------------------------------------------------------------------------
module adc_dsp_rx #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                           BCLK,
    input  logic                           ADCLRCK,
    input  logic                           ADCDAT,
    output logic signed [SAMPLE_WIDTH-1:0] leftSampleOut,
    output logic signed [SAMPLE_WIDTH-1:0] rightSampleOut,
    output logic                           sample_valid,
    output logic                           busy,
    output logic [2:0]                     state_o
);

    localparam int CW = $clog2(SAMPLE_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

    localparam logic [2:0] ST_LEFT   = 3'd0;
    localparam logic [2:0] ST_RIGHT  = 3'd1;
`ifdef ADC_RX_MONO_EN
    localparam logic [2:0] ST_SUM    = 3'd2;
`endif
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] lsr_q, lsr_d;
    logic [SAMPLE_WIDTH-1:0] rsr_q, rsr_d;
    logic                    valid_q, valid_d;

    // The output pair is deliberately outside the ADCLRCK reset so it stays
    // stable across the frame-sync edge on which the echo stage samples it.
    logic [SAMPLE_WIDTH-1:0] lout_q = '0;
    logic [SAMPLE_WIDTH-1:0] rout_q = '0;
    logic [SAMPLE_WIDTH-1:0] lout_d, rout_d;

`ifdef ADC_RX_MONO_EN
    logic [SAMPLE_WIDTH:0]   sum_q, sum_d;
    // The sum LSB is dropped by the halving shift.
    logic                    mono_unused_lsb;
    assign mono_unused_lsb = sum_q[0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lsr_d   = lsr_q;
        rsr_d   = rsr_q;
        valid_d = 1'b0;
        lout_d  = lout_q;
        rout_d  = rout_q;
`ifdef ADC_RX_MONO_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_LEFT: begin
                lsr_d = {lsr_q[SAMPLE_WIDTH-2:0], ADCDAT};
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = ST_RIGHT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RIGHT: begin
                rsr_d = {rsr_q[SAMPLE_WIDTH-2:0], ADCDAT};
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
`ifdef ADC_RX_MONO_EN
                    state_d = ST_SUM;
`else
                    state_d = ST_COMMIT;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef ADC_RX_MONO_EN
            ST_SUM: begin
                // One extra bit so the sum of two full-scale values cannot wrap.
                sum_d   = {lsr_q[SAMPLE_WIDTH-1], lsr_q} + {rsr_q[SAMPLE_WIDTH-1], rsr_q};
                state_d = ST_COMMIT;
            end
`endif
            ST_COMMIT: begin
`ifdef ADC_RX_MONO_EN
                // Arithmetic halve of the widened sum always fits SAMPLE_WIDTH.
                lout_d = sum_q[SAMPLE_WIDTH:1];
                rout_d = sum_q[SAMPLE_WIDTH:1];
`else
                lout_d = lsr_q;
                rout_d = rsr_q;
`endif
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Long frame: remaining bits are ignored until the next sync.
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge BCLK or posedge ADCLRCK) begin
        if (ADCLRCK) begin
            state_q <= ST_LEFT;
            cnt_q   <= '0;
            lsr_q   <= '0;
            rsr_q   <= '0;
            valid_q <= 1'b0;
`ifdef ADC_RX_MONO_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lsr_q   <= lsr_d;
            rsr_q   <= rsr_d;
            valid_q <= valid_d;
`ifdef ADC_RX_MONO_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // While ADCLRCK is high state_q is forced to LEFT, so lout_d/rout_d equal
    // the current outputs and the pair simply holds.
    always_ff @(posedge BCLK) begin
        lout_q <= lout_d;
        rout_q <= rout_d;
    end

    assign leftSampleOut  = lout_q;
    assign rightSampleOut = rout_q;
    assign sample_valid   = valid_q;
    assign busy           = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
    assign state_o        = state_q;

endmodule

// File: tb/tb_adc_dsp_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_dsp_rx
//   Drives DSP mode A frames into adc_dsp_rx. The driver pushes the expected
//   committed pair for every frame long enough to commit; a monitor follows
//   the frame edge count and checks sample_valid, busy and the held output
//   pair every cycle, popping the expected queue on each commit.
// -----------------------------------------------------------------------------
module tb_adc_dsp_rx;

    localparam int W = 16;
`ifdef ADC_RX_MONO_EN
    localparam int COMMIT_EDGE = 34;
`else
    localparam int COMMIT_EDGE = 33;
`endif
    localparam int MIN_LEN = COMMIT_EDGE + 1;

    // ---------------- clock / reset ----------------
    logic BCLK    = 1'b0;
    logic ADCLRCK = 1'b1;
    logic ADCDAT  = 1'b0;
    always #5 BCLK = ~BCLK;

    logic signed [W-1:0] left_out, right_out;
    logic                sample_valid, busy;
    logic [2:0]          state_dbg;

    adc_dsp_rx #(.SAMPLE_WIDTH(W)) dut (
        .BCLK           (BCLK),
        .ADCLRCK        (ADCLRCK),
        .ADCDAT         (ADCDAT),
        .leftSampleOut  (left_out),
        .rightSampleOut (right_out),
        .sample_valid   (sample_valid),
        .busy           (busy),
        .state_o        (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: stereo passes bits through; mono is floor((L+R)/2) on both.
    function automatic logic [2*W-1:0] model_pair(input logic [W-1:0] l, input logic [W-1:0] r);
`ifdef ADC_RX_MONO_EN
        int s;
        logic [W-1:0] m;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        m = s[W-1:0];
        return {m, m};
`else
        return {l, r};
`endif
    endfunction

    // ---------------- driver ----------------
    // len = BCLK periods from this sync pulse to the next one.
    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int len, input logic fill);
        logic [2*W-1:0] bits;
        bits = {l, r};
        @(negedge BCLK);
        ADCLRCK = 1'b1;
        ADCDAT  = 1'b0;
        if (len >= MIN_LEN) exp_q.push_back(model_pair(l, r));
        for (int e = 1; e < len; e++) begin
            @(negedge BCLK);
            ADCLRCK = 1'b0;
            ADCDAT  = (e <= 2*W) ? bits[2*W-e] : fill;
        end
    endtask

    // ---------------- monitor ----------------
    int             edge_cnt = 0;
    logic [W-1:0]   cur_l = '0;
    logic [W-1:0]   cur_r = '0;
    logic [2*W-1:0] popped;

    always @(posedge BCLK) begin
        if (ADCLRCK) edge_cnt = 0;
        else if (edge_cnt < 1000) edge_cnt++;
        #1;
        check("sample_valid", W'(sample_valid), W'(edge_cnt == COMMIT_EDGE));
        check("busy", W'(busy), W'(edge_cnt <= 2*W - 1));
        if (sample_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL commit_without_expected: got valid expected no commit at %0t", $time);
            end else begin
                n_pass++;
                popped = exp_q.pop_front();
                cur_l  = popped[2*W-1:W];
                cur_r  = popped[W-1:0];
            end
        end
        check("left_out", left_out, cur_l);
        check("right_out", right_out, cur_r);
    end

    // ---------------- stimulus ----------------
    initial begin
        // Power-up with sync held high.
        repeat (5) @(negedge BCLK);

        send_frame(16'h1234, 16'hFEDC, 64, 1'b0);
        send_frame(16'hAAAA, 16'h5555, 64, 1'b0);
        send_frame(16'h1111, 16'h2222, 21, 1'b1);   // short: 20 bits then sync
        send_frame(16'hC3A5, 16'h0F0F, 64, 1'b0);
        send_frame(16'h0001, 16'h0002, 64, 1'b1);   // long: 1s after commit
        send_frame(16'h7FFF, 16'h7FFF, 64, 1'b0);
        send_frame(16'h8000, 16'h8000, 64, 1'b1);
        send_frame(16'h7FFF, 16'h8000, MIN_LEN, 1'b0);  // minimum frame
        send_frame(16'h4321, 16'h8765, MIN_LEN - 1, 1'b1);  // one edge short

        for (int i = 0; i < 40; i++) begin
            int len;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(2, MIN_LEN - 1);
            else len = $urandom_range(MIN_LEN, 70);
            send_frame(W'($urandom), W'($urandom), len, 1'($urandom));
        end

        // Closing sync pulse: outputs must hold across it.
        @(negedge BCLK);
        ADCLRCK = 1'b1;
        @(negedge BCLK);
        ADCLRCK = 1'b0;
        ADCDAT  = 1'b0;
        repeat (5) @(negedge BCLK);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_commits: got %0d left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
